// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: round-robin sharing of one multi-cycle muldiv_unit across barrel-CPU harts.
// Optional in-flight watchdog enabled by defining MULDIV_ARB_TIMEOUT_EN.
module muldiv_arbiter #(
    parameter int unsigned NUM_HARTS  = 2,
    parameter int unsigned HART_ID_W  = 1,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
`ifdef MULDIV_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_HARTS-1:0]            req_valid,
    output logic [NUM_HARTS-1:0]            req_ready,
    input  logic [NUM_HARTS*3-1:0]          req_op,
    input  logic [NUM_HARTS*XLEN-1:0]       req_a,
    input  logic [NUM_HARTS*XLEN-1:0]       req_b,
    input  logic [NUM_HARTS*REG_ADDR_W-1:0] req_rd,
    input  logic [NUM_HARTS-1:0]            flush,
    output logic [NUM_HARTS-1:0]            hart_busy,
    output logic                            muldiv_start,
    output logic [2:0]                      muldiv_op,
    output logic [XLEN-1:0]                 muldiv_a,
    output logic [XLEN-1:0]                 muldiv_b,
    output logic [HART_ID_W-1:0]            muldiv_hart_id,
    output logic [REG_ADDR_W-1:0]           muldiv_rd,
    input  logic                            muldiv_busy,
    input  logic                            muldiv_done,
    input  logic [XLEN-1:0]                 muldiv_result,
    input  logic [HART_ID_W-1:0]            muldiv_done_hart_id,
    input  logic [REG_ADDR_W-1:0]           muldiv_done_rd,
    output logic                            wb_valid,
    input  logic                            wb_ready,
    output logic [HART_ID_W-1:0]            wb_hart_id,
    output logic [REG_ADDR_W-1:0]           wb_rd,
    output logic [XLEN-1:0]                 wb_data,
    output logic                            proto_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [HART_ID_W-1:0]  rr_q, rr_d;

    logic [NUM_HARTS-1:0]  slot_vld, busy, accept, slot_take_c, busy_clr_c;
    logic [2:0]            slot_op [NUM_HARTS];
    logic [XLEN-1:0]       slot_a  [NUM_HARTS];
    logic [XLEN-1:0]       slot_b  [NUM_HARTS];
    logic [REG_ADDR_W-1:0] slot_rd [NUM_HARTS];

    logic                  start_q, start_d;
    logic [2:0]            op_q, op_d;
    logic [XLEN-1:0]       a_q, a_d, b_q, b_d;
    logic [HART_ID_W-1:0]  id_q, id_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;

    logic [HART_ID_W-1:0]  tag_hart_q, tag_hart_d;
    logic [REG_ADDR_W-1:0] tag_rd_q, tag_rd_d;
    logic                  killed_q, killed_d;

    logic                  wb_valid_q, wb_valid_d;
    logic [HART_ID_W-1:0]  wb_hart_q, wb_hart_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;
    logic                  proto_err_q, proto_err_d;

    logic                  grant_found;
    logic [HART_ID_W-1:0]  grant_idx, cand;
    logic                  fin;
    logic [XLEN-1:0]       fin_data;

    assign req_ready = ~busy & ~flush;
    assign accept    = req_valid & req_ready;

    // Per-hart holding slot and busy flag
    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_slot
        logic                  vld_q, busy_q;
        logic [2:0]            sop_q;
        logic [XLEN-1:0]       sa_q, sb_q;
        logic [REG_ADDR_W-1:0] srd_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q  <= 1'b0;
                busy_q <= 1'b0;
                sop_q  <= '0;
                sa_q   <= '0;
                sb_q   <= '0;
                srd_q  <= '0;
            end else begin
                if (accept[g]) begin
                    vld_q <= 1'b1;
                    sop_q <= req_op[3*g +: 3];
                    sa_q  <= req_a[XLEN*g +: XLEN];
                    sb_q  <= req_b[XLEN*g +: XLEN];
                    srd_q <= req_rd[REG_ADDR_W*g +: REG_ADDR_W];
                end else if (flush[g] || slot_take_c[g]) begin
                    vld_q <= 1'b0;
                end
                if (accept[g]) begin
                    busy_q <= 1'b1;
                end else if ((flush[g] && vld_q) || busy_clr_c[g]) begin
                    busy_q <= 1'b0;
                end
            end
        end

        assign slot_vld[g] = vld_q;
        assign busy[g]     = busy_q;
        assign slot_op[g]  = sop_q;
        assign slot_a[g]   = sa_q;
        assign slot_b[g]   = sb_q;
        assign slot_rd[g]  = srd_q;
    end

`ifdef MULDIV_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_c;

    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cnt_d     = (state_q == S_WAIT && state_d == S_WAIT) ? cnt_q + CNT_W'(1) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    // Next-state, grant and writeback logic
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        start_d     = 1'b0;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rd_d        = rd_q;
        tag_hart_d  = tag_hart_q;
        tag_rd_d    = tag_rd_q;
        killed_d    = killed_q;
        wb_valid_d  = wb_valid_q;
        wb_hart_d   = wb_hart_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        proto_err_d = proto_err_q;
        slot_take_c = '0;
        busy_clr_c  = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        fin         = 1'b0;
        fin_data    = muldiv_result;

        // Search starts just past the last granted hart; a slot being flushed is skipped
        for (int unsigned i = 1; i <= NUM_HARTS; i++) begin
            cand = HART_ID_W'((32'(rr_q) + i) % NUM_HARTS);
            if (!grant_found && slot_vld[cand] && !flush[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (grant_found && !muldiv_busy) begin
                    start_d     = 1'b1;
                    op_d        = slot_op[grant_idx];
                    a_d         = slot_a[grant_idx];
                    b_d         = slot_b[grant_idx];
                    id_d        = grant_idx;
                    rd_d        = slot_rd[grant_idx];
                    tag_hart_d  = grant_idx;
                    tag_rd_d    = slot_rd[grant_idx];
                    killed_d    = 1'b0;
                    rr_d        = grant_idx;
                    slot_take_c = NUM_HARTS'(1) << grant_idx;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                fin = muldiv_done;
`ifdef MULDIV_ARB_TIMEOUT_EN
                if (!muldiv_done && timeout_c) begin
                    fin         = 1'b1;
                    fin_data    = '1;
                    proto_err_d = 1'b1;
                end
`endif
                if (flush[tag_hart_q]) begin
                    killed_d = 1'b1;
                end
                if (muldiv_done &&
                    (muldiv_done_hart_id != tag_hart_q || muldiv_done_rd != tag_rd_q)) begin
                    proto_err_d = 1'b1;
                end
                if (fin) begin
                    if (killed_q || flush[tag_hart_q]) begin
                        busy_clr_c = NUM_HARTS'(1) << tag_hart_q;
                        killed_d   = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_hart_d  = tag_hart_q;
                        wb_rd_d    = tag_rd_q;
                        wb_data_d  = fin_data;
                        state_d    = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (flush[wb_hart_q] || wb_ready) begin
                    wb_valid_d = 1'b0;
                    busy_clr_c = NUM_HARTS'(1) << wb_hart_q;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            start_q     <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rd_q        <= '0;
            tag_hart_q  <= '0;
            tag_rd_q    <= '0;
            killed_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_hart_q   <= '0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            start_q     <= start_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rd_q        <= rd_d;
            tag_hart_q  <= tag_hart_d;
            tag_rd_q    <= tag_rd_d;
            killed_q    <= killed_d;
            wb_valid_q  <= wb_valid_d;
            wb_hart_q   <= wb_hart_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign hart_busy      = busy;
    assign muldiv_start   = start_q;
    assign muldiv_op      = op_q;
    assign muldiv_a       = a_q;
    assign muldiv_b       = b_q;
    assign muldiv_hart_id = id_q;
    assign muldiv_rd      = rd_q;
    assign wb_valid       = wb_valid_q;
    assign wb_hart_id     = wb_hart_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb_muldiv_arbiter: directed and randomized checks of muldiv_arbiter against an M-extension reference.
module tb_muldiv_arbiter;
    localparam int unsigned NH = 2;
    localparam int unsigned HW = 1;
    localparam int unsigned XL = 32;
    localparam int unsigned RW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NH-1:0]    req_valid = '0, req_ready, flush = '0, hart_busy;
    logic [NH*3-1:0]  req_op = '0;
    logic [NH*XL-1:0] req_a = '0, req_b = '0;
    logic [NH*RW-1:0] req_rd = '0;
    logic             muldiv_start;
    logic [2:0]       muldiv_op;
    logic [XL-1:0]    muldiv_a, muldiv_b;
    logic [HW-1:0]    muldiv_hart_id;
    logic [RW-1:0]    muldiv_rd;
    logic             muldiv_busy = 1'b0, muldiv_done = 1'b0;
    logic [XL-1:0]    muldiv_result = '0;
    logic [HW-1:0]    muldiv_done_hart_id = '0;
    logic [RW-1:0]    muldiv_done_rd = '0;
    logic             wb_valid, wb_ready = 1'b1;
    logic [HW-1:0]    wb_hart_id;
    logic [RW-1:0]    wb_rd;
    logic [XL-1:0]    wb_data;
    logic             proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
        .hart_busy(hart_busy), .muldiv_start(muldiv_start), .muldiv_op(muldiv_op),
        .muldiv_a(muldiv_a), .muldiv_b(muldiv_b), .muldiv_hart_id(muldiv_hart_id),
        .muldiv_rd(muldiv_rd), .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
        .muldiv_result(muldiv_result), .muldiv_done_hart_id(muldiv_done_hart_id),
        .muldiv_done_rd(muldiv_done_rd), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_hart_id(wb_hart_id), .wb_rd(wb_rd), .wb_data(wb_data), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    // RISC-V M-extension reference semantics
    function automatic logic [31:0] mext(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        mext = '0;
        case (op)
            3'd0: begin p = ua * ub; mext = p[31:0];  end
            3'd1: begin p = sa * sb; mext = p[63:32]; end
            3'd2: begin p = sa * ub; mext = p[63:32]; end
            3'd3: begin p = ua * ub; mext = p[63:32]; end
            3'd4: begin
                if (b == 0) mext = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) mext = a;
                else mext = $signed(a) / $signed(b);
            end
            3'd5: mext = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) mext = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) mext = '0;
                else mext = $signed(a) % $signed(b);
            end
            default: mext = (b == 0) ? a : a % b;
        endcase
    endfunction

    // Behavioural muldiv_unit: latches on start, answers after a latency
    int         u_lat = 2;
    bit         u_rand = 1'b0;
    bit         unit_en = 1'b1;
    logic [HW-1:0] tag_flip = '0;
    int         u_cnt = 0;
    logic [2:0] u_op;
    logic [XL-1:0] u_a, u_b;
    logic [HW-1:0] u_hart;
    logic [RW-1:0] u_rd;

    always @(negedge clk) begin
        muldiv_done = 1'b0;
        if (rst) begin
            muldiv_busy = 1'b0;
            u_cnt = 0;
        end else if (muldiv_busy) begin
            if (u_cnt > 0) u_cnt--;
            else if (unit_en) begin
                muldiv_done         = 1'b1;
                muldiv_result       = mext(u_op, u_a, u_b);
                muldiv_done_hart_id = u_hart ^ tag_flip;
                muldiv_done_rd      = u_rd;
                muldiv_busy         = 1'b0;
            end
        end else if (muldiv_start === 1'b1) begin
            u_op = muldiv_op; u_a = muldiv_a; u_b = muldiv_b;
            u_hart = muldiv_hart_id; u_rd = muldiv_rd;
            muldiv_busy = 1'b1;
            u_cnt = u_rand ? int'($urandom_range(0, 6)) : u_lat;
        end
    end

    logic [HW-1:0] issue_log[$];
    always @(negedge clk) if (muldiv_start === 1'b1) issue_log.push_back(muldiv_hart_id);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int h, input logic [2:0] op, input logic [XL-1:0] a,
                           input logic [XL-1:0] b, input logic [RW-1:0] rd);
        req_valid[h]          = 1'b1;
        req_op[3*h +: 3]      = op;
        req_a[XL*h +: XL]     = a;
        req_b[XL*h +: XL]     = b;
        req_rd[RW*h +: RW]    = rd;
    endtask

    task automatic post(input int h, input logic [2:0] op, input logic [XL-1:0] a,
                        input logic [XL-1:0] b, input logic [RW-1:0] rd);
        set_req(h, op, a, b, rd);
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic wait_wb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (wb_valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic expect_wb(input string tag, input int h, input logic [RW-1:0] rd, input logic [XL-1:0] data);
        bit ok;
        wait_wb(ok);
        check({tag, "_seen"}, 128'(ok), 128'(1));
        if (ok) check(tag, {wb_hart_id, wb_rd, wb_data}, {HW'(h), rd, data});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; flush = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Random-phase scoreboard: one outstanding op per hart
    logic [NH-1:0] pend = '0;
    logic [2:0]    exp_op  [NH];
    logic [XL-1:0] exp_a   [NH], exp_b [NH], exp_res [NH];
    logic [RW-1:0] exp_rd  [NH];
    int n_post = 0, n_done = 0;

    task automatic rand_cycle(input bit allow_req);
        int h;
        logic [2:0] op; logic [XL-1:0] a, b; logic [RW-1:0] rd;
        req_valid = '0;
        wb_ready = 1'($urandom_range(0, 1));
        if (muldiv_start === 1'b1) begin
            h = int'(muldiv_hart_id);
            check("rnd_issue_pend", 128'(pend[h]), 128'(1));
            check("rnd_issue", {muldiv_op, muldiv_a, muldiv_b, muldiv_rd},
                  {exp_op[h], exp_a[h], exp_b[h], exp_rd[h]});
        end
        if (wb_valid === 1'b1) begin
            h = int'(wb_hart_id);
            check("rnd_wb_pend", 128'(pend[h]), 128'(1));
            check("rnd_wb", {wb_rd, wb_data}, {exp_rd[h], exp_res[h]});
            if (wb_ready) begin pend[h] = 1'b0; n_done++; end
        end
        if (allow_req) begin
            for (int k = 0; k < NH; k++) begin
                if (!pend[k] && req_ready[k] && $urandom_range(0, 2) == 0) begin
                    op = 3'($urandom_range(0, 7));
                    a  = $urandom;
                    b  = ($urandom_range(0, 3) == 0) ? XL'($urandom_range(0, 2)) : $urandom;
                    rd = RW'($urandom);
                    exp_op[k] = op; exp_a[k] = a; exp_b[k] = b; exp_rd[k] = rd;
                    exp_res[k] = mext(op, a, b);
                    pend[k] = 1'b1;
                    n_post++;
                    set_req(k, op, a, b, rd);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        do_reset();
        check("rst_outputs", {wb_valid, muldiv_start, hart_busy, proto_err, wb_data, muldiv_a}, '0);

        // Single MUL
        issue_log.delete();
        post(0, 3'd0, 32'd10, 32'd3, 5'd3);
        expect_wb("mul_wb", 0, 5'd3, 32'd30);
        check("mul_busy_clr", 128'(hart_busy[0]), 128'(0));
        check("mul_issues", 128'(issue_log.size()), 128'(1));
        if (issue_log.size() > 0) check("mul_issue_id", 128'(issue_log[0]), 128'(0));

        // DIV then REM on the same hart
        post(0, 3'd4, 32'd10, 32'd3, 5'd4);
        check("div_ready_low", 128'(req_ready[0]), 128'(0));
        expect_wb("div_wb", 0, 5'd4, 32'd3);
        post(0, 3'd6, 32'd10, 32'd3, 5'd5);
        expect_wb("rem_wb", 0, 5'd5, 32'd1);

        // Simultaneous requests after reset: hart1 first
        do_reset();
        issue_log.delete();
        set_req(0, 3'd0, 32'd7, 32'd6, 5'd1);
        set_req(1, 3'd0, 32'd7, 32'd6, 5'd2);
        @(negedge clk);
        req_valid = '0;
        expect_wb("rr_first", 1, 5'd2, 32'd42);
        expect_wb("rr_second", 0, 5'd1, 32'd42);
        check("rr_order", {120'(issue_log.size()), issue_log.size() > 1 ? issue_log[0] : 1'b0,
                           issue_log.size() > 1 ? issue_log[1] : 1'b1}, {120'(2), 1'b1, 1'b0});

        // Writeback backpressure
        wb_ready = 1'b0;
        post(0, 3'd0, 32'd11, 32'd11, 5'd8);
        post(1, 3'd3, 32'hFFFF_FFFF, 32'd2, 5'd9);
        wait_wb(ok);
        check("bp_seen", 128'(ok), 128'(1));
        check("bp_first", {wb_hart_id, wb_rd, wb_data}, {1'b0, 5'd8, 32'd121});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {wb_valid, wb_hart_id, wb_rd, wb_data, muldiv_start},
                  {1'b1, 1'b0, 5'd8, 32'd121, 1'b0});
        end
        wb_ready = 1'b1;
        @(negedge clk);
        check("bp_after_hs", {wb_valid, muldiv_start}, {1'b0, 1'b0});
        @(negedge clk);
        check("bp_next_start", {muldiv_start, muldiv_hart_id}, {1'b1, 1'b1});
        expect_wb("bp_second", 1, 5'd9, 32'd1);

        // Flush of the in-flight op; pending hart0 op issues next
        u_lat = 8;
        post(1, 3'd5, 32'd100, 32'd7, 5'd10);
        post(0, 3'd0, 32'd4, 32'd5, 5'd11);
        flush[1] = 1'b1;
        @(negedge clk);
        flush = '0;
        check("flush_busy_held", 128'(hart_busy[1]), 128'(1));
        expect_wb("flush_next", 0, 5'd11, 32'd20);
        check("flush_busy_clr", 128'(hart_busy[1]), 128'(0));

        // Flush during writeback drops it
        u_lat = 2;
        wb_ready = 1'b0;
        post(1, 3'd7, 32'd100, 32'd7, 5'd12);
        wait_wb(ok);
        check("rflush_seen", {ok, wb_data}, {1'b1, 32'd2});
        flush[1] = 1'b1;
        @(negedge clk);
        flush = '0;
        check("rflush_drop", {wb_valid, hart_busy[1]}, {1'b0, 1'b0});
        wb_ready = 1'b1;

        // Tag mismatch from the unit: latched tag wins, sticky error
        tag_flip = 1'b1;
        post(0, 3'd0, 32'd2, 32'd3, 5'd7);
        expect_wb("tag_wb", 0, 5'd7, 32'd6);
        tag_flip = 1'b0;
        check("tag_err", 128'(proto_err), 128'(1));
        post(1, 3'd0, 32'd1, 32'd1, 5'd1);
        expect_wb("tag_ok_wb", 1, 5'd1, 32'd1);
        check("tag_err_sticky", 128'(proto_err), 128'(1));

        // Reset in the middle of an op
        u_lat = 8;
        post(0, 3'd0, 32'd9, 32'd9, 5'd6);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_mid", {muldiv_start, wb_valid, hart_busy, proto_err, muldiv_a, wb_data, muldiv_hart_id},
                 '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        u_lat = 2;
        @(negedge clk);
        post(0, 3'd0, 32'd5, 32'd5, 5'd13);
        expect_wb("post_rst_mul", 0, 5'd13, 32'd25);

        // Randomized traffic against the scoreboard
        do_reset();
        u_rand = 1'b1;
        pend = '0;
        for (int c = 0; c < 400; c++) rand_cycle(1'b1);
        for (int c = 0; c < 400 && pend != '0; c++) rand_cycle(1'b0);
        check("rnd_drained", 128'(pend), 128'(0));
        check("rnd_count", 128'(n_done), 128'(n_post));
        u_rand = 1'b0;
        wb_ready = 1'b1;
        req_valid = '0;

`ifdef MULDIV_ARB_TIMEOUT_EN
        // Watchdog with the unit never answering
        do_reset();
        unit_en = 1'b0;
        post(0, 3'd0, 32'd3, 32'd3, 5'd2);
        wait_wb(ok);
        check("to_wb", {ok, wb_hart_id, wb_rd, wb_data, proto_err}, {1'b1, 1'b0, 5'd2, 32'hFFFF_FFFF, 1'b1});
        unit_en = 1'b1;
        do_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
